// File: rtl/wave_src.sv
// Waveform sample source for the AD5791 tx write port.
// A phase accumulator drives a DC/square/sawtooth/triangle shaper, followed by gain, offset and
// saturation stages. Samples are paced by a divider, held under tx_waitrequest backpressure and
// can be issued continuously or as a fixed-length burst.
module wave_src #(
  parameter int unsigned DATA_NBIT  = 20,
  parameter int unsigned PHASE_NBIT = 32,
  parameter int unsigned DIV_NBIT   = 16,
  parameter int unsigned CNT_NBIT   = 16
) (
  input  logic                  tx_clk,
  input  logic                  rst,
  input  logic                  cfg_load,
  input  logic [1:0]            cfg_wave,
  input  logic [PHASE_NBIT-1:0] cfg_freq,
  input  logic [PHASE_NBIT-1:0] cfg_phase0,
  input  logic [DATA_NBIT-1:0]  cfg_amp,
  input  logic [DATA_NBIT-1:0]  cfg_offset,
  input  logic [DIV_NBIT-1:0]   cfg_div,
  input  logic [CNT_NBIT-1:0]   cfg_nsamp,
  input  logic                  run,
  output logic                  tx_dv,
  output logic [DATA_NBIT-1:0]  tx_data,
  input  logic                  tx_waitrequest,
  output logic                  busy,
  output logic                  stall
);

  localparam int unsigned N = DATA_NBIT;

  // Full-scale constants of the N-bit two's-complement code space.
  localparam logic [N-1:0] SqPos  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SqNeg  = {1'b1, {(N-2){1'b0}}, 1'b1};
  localparam logic [N-1:0] SatMax = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SatMin = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;

  // Shadow configuration
  logic [1:0]            sh_wave_q;
  logic [PHASE_NBIT-1:0] sh_freq_q;
  logic [PHASE_NBIT-1:0] sh_phase0_q;
  logic [N-1:0]          sh_amp_q;
  logic [N-1:0]          sh_offset_q;
  logic [DIV_NBIT-1:0]   sh_div_q;
  logic [CNT_NBIT-1:0]   sh_nsamp_q;

  // Per-run copies, frozen at the IDLE to RUN transition
  logic [DIV_NBIT-1:0]   div_q;
  logic [CNT_NBIT-1:0]   nsamp_q;

  // Sequencer state
  logic [DIV_NBIT-1:0]   div_cnt_q;
  logic [PHASE_NBIT-1:0] phase_q;
  logic [CNT_NBIT-1:0]   burst_cnt_q;

  // Pipeline registers
  logic                  v1_q;
  logic signed [N-1:0]   s1_q;
  logic [N-1:0]          s1_amp_q;
  logic [N-1:0]          s1_off_q;
  logic                  v2_q;
  logic signed [N:0]     m2_q;
  logic [N-1:0]          s2_off_q;
  logic                  out_vld_q;
  logic [N-1:0]          out_data_q;

  logic                  stall_q;

  // Combinational helpers
  logic                  en;
  logic                  start;
  logic                  burst_done;
  logic                  tick;
  logic [N-1:0]          p;
  logic [N-2:0]          tri_t;
  logic [N-1:0]          shape;
  logic signed [2*N:0]   prod;
  logic signed [N:0]     m_d;
  logic signed [N:0]     sum;
  logic [N-1:0]          sat;

  // The whole datapath freezes only while a presented sample is being refused.
  assign en         = ~(out_vld_q & tx_waitrequest);
  assign start      = (state_q == StIdle) & run;
  assign burst_done = (nsamp_q != '0) && (burst_cnt_q == nsamp_q);
  assign tick       = (state_q == StRun) & en & run & ~burst_done & (div_cnt_q == div_q);

  assign tx_dv   = out_vld_q & ~tx_waitrequest;
  assign tx_data = out_data_q;
  assign busy    = (state_q != StIdle);
  assign stall   = stall_q;

  // FSM state register
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; DRAIN exits in the same cycle the last sample is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (run) state_d = StRun;
      end
      StRun: begin
        if (!run || burst_done) state_d = StDrain;
      end
      StDrain: begin
        if (!v1_q && !v2_q && (!out_vld_q || tx_dv)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Shadow configuration capture
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      sh_wave_q   <= '0;
      sh_freq_q   <= '0;
      sh_phase0_q <= '0;
      sh_amp_q    <= '0;
      sh_offset_q <= '0;
      sh_div_q    <= '0;
      sh_nsamp_q  <= '0;
    end else if (cfg_load) begin
      sh_wave_q   <= cfg_wave;
      sh_freq_q   <= cfg_freq;
      sh_phase0_q <= cfg_phase0;
      sh_amp_q    <= cfg_amp;
      sh_offset_q <= cfg_offset;
      sh_div_q    <= cfg_div;
      sh_nsamp_q  <= cfg_nsamp;
    end
  end

  // Divider, phase accumulator and burst counter
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      div_q       <= '0;
      nsamp_q     <= '0;
      div_cnt_q   <= '0;
      phase_q     <= '0;
      burst_cnt_q <= '0;
    end else if (start) begin
      div_q       <= sh_div_q;
      nsamp_q     <= sh_nsamp_q;
      div_cnt_q   <= '0;
      phase_q     <= sh_phase0_q;
      burst_cnt_q <= '0;
    end else if ((state_q == StRun) && en) begin
      if (div_cnt_q == div_q) begin
        div_cnt_q <= '0;
      end else begin
        div_cnt_q <= div_cnt_q + DIV_NBIT'(1);
      end
      if (tick) begin
        phase_q     <= phase_q + sh_freq_q;
        burst_cnt_q <= burst_cnt_q + CNT_NBIT'(1);
      end
    end
  end

  // Stage 1 shaper: map the top N phase bits onto a signed sample
  always_comb begin
    p     = phase_q[PHASE_NBIT-1 -: N];
    tri_t = p[N-1] ? ~p[N-2:0] : p[N-2:0];
    shape = '0;
    case (sh_wave_q)
      2'b00: shape = '0;
      2'b01: shape = p[N-1] ? SqNeg : SqPos;
      // p - 2^(N-1) is just an MSB flip
      2'b10: shape = {~p[N-1], p[N-2:0]};
      // 2t - 2^(N-1): shift left, then flip the new MSB
      2'b11: shape = {~tri_t[N-2], tri_t[N-3:0], 1'b0};
    endcase
  end

  // Stage 2 gain (amp zero-extended so it stays non-negative) and stage 3 offset/saturate
  always_comb begin
    prod = $signed(s1_q) * $signed({1'b0, s1_amp_q});
    // |s*amp| < 2^(2N-1), so the floored quotient always fits N+1 bits
    m_d  = (N+1)'(prod >>> N);
    sum  = m2_q + $signed({s2_off_q[N-1], s2_off_q});
    if (sum[N] != sum[N-1]) begin
      sat = sum[N] ? SatMin : SatMax;
    end else begin
      sat = sum[N-1:0];
    end
  end

  // Three-stage sample pipeline; waveform parameters travel with the sample they were ticked with
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      s1_q       <= '0;
      s1_amp_q   <= '0;
      s1_off_q   <= '0;
      v2_q       <= 1'b0;
      m2_q       <= '0;
      s2_off_q   <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else if (en) begin
      v1_q <= tick;
      if (tick) begin
        s1_q     <= shape;
        s1_amp_q <= sh_amp_q;
        s1_off_q <= sh_offset_q;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        m2_q     <= m_d;
        s2_off_q <= s1_off_q;
      end
      out_vld_q <= v2_q;
      if (v2_q) begin
        out_data_q <= sat;
      end
    end
  end

  // Sticky backpressure flag; a refusal in the same cycle as cfg_load is not lost
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      stall_q <= 1'b0;
    end else if (!en && (state_q != StIdle)) begin
      stall_q <= 1'b1;
    end else if (cfg_load) begin
      stall_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wave_src.sv
// Directed self-checking bench for wave_src. Inputs change 1 ns after the rising edge and
// outputs are sampled 1 ns later, so tx_dv reflects the tx_waitrequest applied that cycle.
module tb_wave_src;

  logic        tx_clk = 1'b0;
  logic        rst;
  logic        cfg_load;
  logic [1:0]  cfg_wave;
  logic [31:0] cfg_freq;
  logic [31:0] cfg_phase0;
  logic [19:0] cfg_amp;
  logic [19:0] cfg_offset;
  logic [15:0] cfg_div;
  logic [15:0] cfg_nsamp;
  logic        run;
  logic        tx_dv;
  logic [19:0] tx_data;
  logic        tx_waitrequest;
  logic        busy;
  logic        stall;

  int n_cmp = 0;
  int n_bad = 0;

  // Sawtooth, freq 2^28, amp 0xFFFFF: negative codes are exact, positive ones floor one LSB low.
  logic [19:0] saw_tbl [16] = '{20'h80000, 20'h90000, 20'hA0000, 20'hB0000,
                                20'hC0000, 20'hD0000, 20'hE0000, 20'hF0000,
                                20'h00000, 20'h0FFFF, 20'h1FFFF, 20'h2FFFF,
                                20'h3FFFF, 20'h4FFFF, 20'h5FFFF, 20'h6FFFF};
  // Triangle, freq 2^28, amp 0xFFFFF: s = 2t - 2^19 with t = 0, 0x10000, ... 0x40000
  logic [19:0] tri_tbl [5]  = '{20'h80000, 20'hA0000, 20'hC0000, 20'hE0000, 20'h00000};

  always #5 tx_clk = ~tx_clk;

  wave_src dut (
    .tx_clk         (tx_clk),
    .rst            (rst),
    .cfg_load       (cfg_load),
    .cfg_wave       (cfg_wave),
    .cfg_freq       (cfg_freq),
    .cfg_phase0     (cfg_phase0),
    .cfg_amp        (cfg_amp),
    .cfg_offset     (cfg_offset),
    .cfg_div        (cfg_div),
    .cfg_nsamp      (cfg_nsamp),
    .run            (run),
    .tx_dv          (tx_dv),
    .tx_data        (tx_data),
    .tx_waitrequest (tx_waitrequest),
    .busy           (busy),
    .stall          (stall)
  );

  task automatic next_cycle();
    @(posedge tx_clk);
    #1;
  endtask

  // Pulse cfg_load; returns in the first cycle after the shadow registers updated.
  task automatic load_cfg(input logic [1:0] w, input logic [31:0] f, input logic [31:0] p0,
                          input logic [19:0] a, input logic [19:0] o, input logic [15:0] d,
                          input logic [15:0] ns);
    next_cycle();
    cfg_wave   = w;
    cfg_freq   = f;
    cfg_phase0 = p0;
    cfg_amp    = a;
    cfg_offset = o;
    cfg_div    = d;
    cfg_nsamp  = ns;
    cfg_load   = 1'b1;
    next_cycle();
    cfg_load = 1'b0;
  endtask

  task automatic go_idle(output bit ok);
    ok  = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_load = 1'b0; cfg_wave = '0; cfg_freq = '0; cfg_phase0 = '0; cfg_amp = '0;
    cfg_offset = '0; cfg_div = '0; cfg_nsamp = '0; run = 1'b0; tx_waitrequest = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    n_cmp++; if (tx_dv !== 1'b0) begin n_bad++; $display("FAIL reset_tx_dv got %b want 0", tx_dv); end
    n_cmp++; if (tx_data !== 20'h0) begin n_bad++; $display("FAIL reset_tx_data got %h want 00000", tx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall); end
  endtask

  task automatic test_sawtooth();
    bit ok;
    load_cfg(2'b10, 32'h1000_0000, 32'h0, 20'hFFFFF, 20'h0, 16'd0, 16'd0);
    run = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      next_cycle();
      #1;
      if (i < 4) begin
        n_cmp++;
        if (tx_dv !== 1'b0) begin n_bad++; $display("FAIL saw_latency cycle %0d tx_dv got %b want 0", i, tx_dv); end
      end else begin
        n_cmp++;
        if (tx_dv !== 1'b1 || tx_data !== saw_tbl[(i-4)%16]) begin
          n_bad++;
          $display("FAIL saw_ramp cycle %0d got dv=%b data=%h want dv=1 data=%h", i, tx_dv, tx_data, saw_tbl[(i-4)%16]);
        end
      end
    end
    go_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL saw_idle busy got 1 want 0"); end
  endtask

  // Square, div 3: samples every 4 cycles; first tick on RUN cycle 3 lands at cycle 7.
  task automatic test_square();
    bit ok;
    logic [19:0] want [2][2];
    int pulses, last;
    // Offset +max: +524286 saturates high; -524287 + 524287 = 0.
    want[0][0] = 20'h7FFFF; want[0][1] = 20'h00000;
    // Offset -2^19: 524286 - 524288 = -2; -524287 - 524288 saturates low.
    want[1][0] = 20'hFFFFE; want[1][1] = 20'h80000;
    for (int c = 0; c < 2; c++) begin
      load_cfg(2'b01, 32'h8000_0000, 32'h0, 20'hFFFFF, (c == 0) ? 20'h7FFFF : 20'h80000,
               16'd3, 16'd0);
      run = 1'b1;
      pulses = 0;
      last = 3;
      for (int i = 1; i <= 20; i++) begin
        next_cycle();
        #1;
        if (tx_dv) begin
          n_cmp++;
          if (i - last != 4) begin n_bad++; $display("FAIL sq_spacing cfg %0d cycle %0d got gap %0d want 4", c, i, i - last); end
          n_cmp++;
          if (tx_data !== want[c][pulses%2]) begin
            n_bad++;
            $display("FAIL sq_data cfg %0d pulse %0d got %h want %h", c, pulses, tx_data, want[c][pulses%2]);
          end
          pulses++;
          last = i;
        end
      end
      n_cmp++; if (pulses != 4) begin n_bad++; $display("FAIL sq_count cfg %0d got %0d want 4", c, pulses); end
      go_idle(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL sq_idle busy got 1 want 0"); end
    end
  endtask

  // DC with offset; a mid-run offset change reaches the output with the first tick after loading.
  task automatic test_dc_offset();
    bit ok;
    logic [19:0] want;
    load_cfg(2'b00, 32'h0, 32'h0, 20'h12345, 20'hFEDCB, 16'd0, 16'd0);
    run = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      next_cycle();
      cfg_load = (i == 6);
      if (i == 6) cfg_offset = 20'h00100;
      #1;
      // Ticks in cycles 1..6 use the old offset; the tick in cycle 7 is delivered in cycle 10.
      want = (i < 10) ? 20'hFEDCB : 20'h00100;
      if (i >= 4) begin
        n_cmp++;
        if (tx_dv !== 1'b1 || tx_data !== want) begin
          n_bad++;
          $display("FAIL dc_offset cycle %0d got dv=%b data=%h want dv=1 data=%h", i, tx_dv, tx_data, want);
        end
      end
    end
    go_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL dc_idle busy got 1 want 0"); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int idx;
    load_cfg(2'b10, 32'h1000_0000, 32'h0, 20'hFFFFF, 20'h0, 16'd0, 16'd0);
    run = 1'b1;
    idx = 0;
    for (int i = 1; i <= 40; i++) begin
      next_cycle();
      tx_waitrequest = (i >= 8 && i <= 17);
      #1;
      if (i == 7) begin
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL bp_stall_pre got %b want 0", stall); end
      end
      if (tx_waitrequest) begin
        n_cmp++;
        if (tx_dv !== 1'b0 || tx_data !== saw_tbl[idx%16]) begin
          n_bad++;
          $display("FAIL bp_hold cycle %0d got dv=%b data=%h want dv=0 data=%h", i, tx_dv, tx_data, saw_tbl[idx%16]);
        end
      end else if (tx_dv) begin
        n_cmp++;
        if (tx_data !== saw_tbl[idx%16]) begin
          n_bad++;
          $display("FAIL bp_seq sample %0d got %h want %h", idx, tx_data, saw_tbl[idx%16]);
        end
        idx++;
      end
    end
    n_cmp++; if (idx != 27) begin n_bad++; $display("FAIL bp_count got %0d want 27", idx); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL bp_stall_set got %b want 1", stall); end
    next_cycle();
    cfg_load = 1'b1;
    next_cycle();
    cfg_load = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL bp_stall_clear got %b want 0", stall); end
    go_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_idle busy got 1 want 0"); end
  endtask

  // Burst of 5 with run held through the drain; run is released once busy has dropped.
  task automatic test_burst();
    int cnt;
    bit after_last, checked;
    load_cfg(2'b11, 32'h1000_0000, 32'h0, 20'hFFFFF, 20'h0, 16'd1, 16'd5);
    run = 1'b1;
    cnt = 0;
    after_last = 1'b0;
    checked = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      next_cycle();
      if (after_last) run = 1'b0;
      #1;
      if (after_last && !checked) begin
        checked = 1'b1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL burst_busy_fall got %b want 0", busy); end
      end
      if (tx_dv) begin
        if (cnt < 5) begin
          n_cmp++;
          if (tx_data !== tri_tbl[cnt]) begin
            n_bad++;
            $display("FAIL burst_data pulse %0d got %h want %h", cnt, tx_data, tri_tbl[cnt]);
          end
        end
        cnt++;
      end
      if (cnt == 5) after_last = 1'b1;
    end
    n_cmp++; if (cnt != 5) begin n_bad++; $display("FAIL burst_count got %0d want 5", cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL burst_end_busy got %b want 0", busy); end
  endtask

  // run high for cycles 0..6 issues ticks in cycles 1..6; all six reach the output.
  task automatic test_run_drop();
    int cnt;
    load_cfg(2'b10, 32'h1000_0000, 32'h0, 20'hFFFFF, 20'h0, 16'd0, 16'd0);
    run = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 25; i++) begin
      next_cycle();
      if (i == 7) run = 1'b0;
      #1;
      if (i == 9) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL drop_draining busy got %b want 1", busy); end
      end
      if (tx_dv) begin
        n_cmp++;
        if (cnt >= 16 || tx_data !== saw_tbl[cnt%16]) begin
          n_bad++;
          $display("FAIL drop_data sample %0d got %h want %h", cnt, tx_data, saw_tbl[cnt%16]);
        end
        cnt++;
      end
    end
    n_cmp++; if (cnt != 6) begin n_bad++; $display("FAIL drop_count got %0d want 6", cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_idle busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    load_cfg(2'b10, 32'h1000_0000, 32'h0, 20'hFFFFF, 20'h0, 16'd0, 16'd0);
    run = 1'b1;
    seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      #1;
      if (tx_dv) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rstmid_first_sample got none want tx_dv within 10 cycles"); end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    run = 1'b0;
    #1;
    n_cmp++; if (tx_dv !== 1'b0) begin n_bad++; $display("FAIL rstmid_tx_dv got %b want 0", tx_dv); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (tx_data !== 20'h0) begin n_bad++; $display("FAIL rstmid_tx_data got %h want 00000", tx_data); end
  endtask

  initial begin
    test_reset();
    test_sawtooth();
    test_square();
    test_dc_offset();
    test_backpressure();
    test_burst();
    test_run_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
